// File: rtl/bus_keyed_sequencer.sv
// Bus-stepped keyed sequencer: a nibble key presented on address reads unlocks an
// LFSR whose tapped parity is returned, one bit per qualified read.
module bus_keyed_sequencer #(
  parameter int                  STATE_W   = 6,
  parameter int                  ADDR_W    = 14,
  parameter logic [ADDR_W-1:0]   WIN_MASK  = 14'h3000,
  parameter logic [ADDR_W-1:0]   WIN_MATCH = 14'h1000,
  parameter int                  CMD_LSB   = 4,
  parameter int                  KEY_LEN   = 4,
  parameter logic [31:0]         KEY       = 32'h0000_A259,
  parameter logic [STATE_W-1:0]  SEED      = 6'h21,
  parameter logic [STATE_W-1:0]  POLY      = 6'h30,
  parameter logic [STATE_W-1:0]  TAP_MASK  = 6'h2D,
  parameter int                  CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  ba,
  input  logic               sser_n,
  input  logic               br_w,
  output logic               sd_out,
  output logic               sd_oe,
  output logic               unlocked,
  output logic [CNT_W-1:0]   step_cnt,
  output logic [STATE_W-1:0] state_q
);

  localparam int IDX_W = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;

  typedef enum logic {LOCKED, UNLOCKED} st_e;

  st_e                st_q, st_d;
  logic               win, rd_acc, wr_acc;
  logic               rd_d, wr_d, blk;
  logic               rd_evt, wr_evt;
  logic [3:0]         cmd, key_nib;
  logic               key_hit, key_first, key_last;
  logic [IDX_W-1:0]   idx;
  logic [STATE_W-1:0] lfsr, lfsr_nxt;
  logic [CNT_W-1:0]   cnt;

  // Bus decode
  assign win    = ((ba & WIN_MASK) == WIN_MATCH) && !sser_n;
  assign rd_acc = win && br_w;
  assign wr_acc = win && !br_w;
  assign cmd    = ba[CMD_LSB +: 4];

  // blk survives reset release until the select drops, so an access held
  // across reset never turns into an event.
  assign rd_evt = rd_acc && !rd_d && !blk;
  assign wr_evt = wr_acc && !wr_d && !blk;

  always_comb begin
    key_nib = '0;
    for (int i = 0; i < KEY_LEN; i++)
      if (idx == IDX_W'(i)) key_nib = KEY[4*i +: 4];
  end

  assign key_hit   = (cmd == key_nib);
  assign key_first = (cmd == KEY[3:0]);
  assign key_last  = (idx == IDX_W'(KEY_LEN-1));

  always_comb begin
    if (lfsr == '0) lfsr_nxt = SEED;
    else            lfsr_nxt = (lfsr >> 1) ^ (lfsr[0] ? POLY : '0);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= LOCKED;
    else        st_q <= st_d;
  end

  // FSM next state
  always_comb begin
    st_d = st_q;
    case (st_q)
      LOCKED:   if (rd_evt && key_hit && key_last) st_d = UNLOCKED;
      UNLOCKED: if (wr_evt)                        st_d = LOCKED;
      default:  st_d = LOCKED;
    endcase
  end

  // FSM outputs
  always_comb begin
    unlocked = (st_q == UNLOCKED);
    sd_oe    = rd_acc;
    step_cnt = cnt;
    state_q  = lfsr;
  end

  // Datapath: edge detect, key index, LFSR, step counter, data bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_d   <= 1'b0;
      wr_d   <= 1'b0;
      blk    <= 1'b1;
      idx    <= '0;
      lfsr   <= SEED;
      cnt    <= '0;
      sd_out <= 1'b0;
    end else begin
      rd_d <= rd_acc;
      wr_d <= wr_acc;
      blk  <= blk && win;
      case (st_q)
        LOCKED: begin
          if (rd_evt) begin
            sd_out <= 1'b0;
            if (key_hit) begin
              if (key_last) begin
                idx  <= '0;
                lfsr <= SEED;
                cnt  <= '0;
              end else begin
                idx <= idx + IDX_W'(1);
              end
            end else if (key_first) begin
              idx <= IDX_W'(1);
            end else begin
              idx <= '0;
            end
          end else if (wr_evt) begin
            idx <= '0;
          end
        end
        UNLOCKED: begin
          if (rd_evt) begin
            sd_out <= ^(lfsr & TAP_MASK);
            lfsr   <= lfsr_nxt;
            if (cnt != '1) cnt <= cnt + CNT_W'(1);
          end else if (wr_evt) begin
            lfsr   <= SEED;
            idx    <= '0;
            sd_out <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
